// File: rtl/count_monitor_if.sv
// Sample stream from the up/down counter into the sequence monitor.
interface count_monitor_if #(
  parameter int WIDTH = 3
);
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic             mode;

  modport master (output sample_valid, output sample, output mode);
  modport slave  (input  sample_valid, input  sample, input  mode);
endinterface

// File: rtl/count_monitor.sv
// Up/down count sequence monitor: acquires lock on a +/-1 stream,
// reports step errors while locked and flags loss of lock.
module count_monitor #(
  parameter int WIDTH     = 3,
  parameter int LOCK_LEN  = 2,
  parameter int ERR_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  count_monitor_if.slave    mon,
  output logic [1:0]        state,
  output logic              locked,
  output logic              lost,
  output logic              err_pulse,
  output logic [7:0]        err_count,
  output logic [WIDTH-1:0]  last_sample
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_LEN);
  localparam logic [3:0] ERR_TGT  = 4'(ERR_LIMIT);

  state_t           state_q, state_n;
  logic [3:0]       good_q, good_n;
  logic [3:0]       bad_q, bad_n;
  logic [7:0]       errc_q, errc_n;
  logic             lost_q, lost_n;
  logic             pulse_q, pulse_n;
  logic             locked_q;
  logic [WIDTH-1:0] last_q, last_n;
  logic [WIDTH-1:0] expected;
  logic             match;

  // Error counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Value the stream should show next, wrapping modulo 2^WIDTH.
  always_comb begin
    expected = mon.mode ? last_q + WIDTH'(1) : last_q - WIDTH'(1);
    match    = (mon.sample == expected);
  end

  // Next-state and counter/flag updates; clear outranks a sample in the same cycle.
  always_comb begin
    state_n = state_q;
    good_n  = good_q;
    bad_n   = bad_q;
    errc_n  = errc_q;
    lost_n  = lost_q;
    last_n  = last_q;
    pulse_n = 1'b0;
    if (clear) begin
      state_n = IDLE;
      good_n  = 4'd0;
      bad_n   = 4'd0;
      errc_n  = 8'd0;
      lost_n  = 1'b0;
      last_n  = '0;
    end else if (mon.sample_valid) begin
      last_n = mon.sample;
      unique case (state_q)
        IDLE, LOST: begin
          good_n  = 4'd0;
          state_n = ACQUIRE;
        end
        ACQUIRE: begin
          if (match) begin
            good_n = good_q + 4'd1;
            if (good_q + 4'd1 == LOCK_TGT) begin
              state_n = LOCKED;
              bad_n   = 4'd0;
            end
          end else begin
            good_n = 4'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            bad_n = 4'd0;
          end else begin
            pulse_n = 1'b1;
            errc_n  = sat_inc8(errc_q);
            bad_n   = bad_q + 4'd1;
            if (bad_q + 4'd1 == ERR_TGT) begin
              state_n = LOST;
              lost_n  = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      good_q   <= 4'd0;
      bad_q    <= 4'd0;
      errc_q   <= 8'd0;
      lost_q   <= 1'b0;
      pulse_q  <= 1'b0;
      locked_q <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_n;
      good_q   <= good_n;
      bad_q    <= bad_n;
      errc_q   <= errc_n;
      lost_q   <= lost_n;
      pulse_q  <= pulse_n;
      locked_q <= (state_n == LOCKED);
      last_q   <= last_n;
    end
  end

  assign state       = state_q;
  assign locked      = locked_q;
  assign lost        = lost_q;
  assign err_pulse   = pulse_q;
  assign err_count   = errc_q;
  assign last_sample = last_q;

endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: directed scenarios plus a randomized run against a reference model.
module tb_count_monitor;

  localparam int W         = 3;
  localparam int LOCK_LEN  = 2;
  localparam int ERR_LIMIT = 3;

  logic         clk;
  logic         rst;
  logic         clear;
  logic [1:0]   state;
  logic         locked, lost, err_pulse;
  logic [7:0]   err_count;
  logic [W-1:0] last_sample;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_state, m_good, m_bad, m_errc, m_lost, m_pulse, m_last;

  count_monitor_if #(.WIDTH(W)) mon_if ();

  count_monitor #(.WIDTH(W), .LOCK_LEN(LOCK_LEN), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk(clk), .rst(rst), .clear(clear), .mon(mon_if),
    .state(state), .locked(locked), .lost(lost), .err_pulse(err_pulse),
    .err_count(err_count), .last_sample(last_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int next_of(input int last, input logic m);
    return (last + (m ? 1 : (1 << W) - 1)) % (1 << W);
  endfunction

  task automatic model_reset();
    m_state = 0; m_good = 0; m_bad = 0; m_errc = 0;
    m_lost = 0; m_pulse = 0; m_last = 0;
  endtask

  task automatic model_update(input logic v, input int s, input logic m, input logic c);
    bit ok;
    m_pulse = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      ok = (s == next_of(m_last, m));
      m_last = s;
      if (m_state == 0 || m_state == 3) begin
        m_good = 0;
        m_state = 1;
      end else if (m_state == 1) begin
        m_good = ok ? m_good + 1 : 0;
        if (m_good == LOCK_LEN) begin
          m_state = 2;
          m_bad = 0;
        end
      end else if (ok) begin
        m_bad = 0;
      end else begin
        m_pulse = 1;
        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
        m_bad++;
        if (m_bad == ERR_LIMIT) begin
          m_state = 3;
          m_lost = 1;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"},     32'(state),       32'(m_state));
    chk({tag, ".locked"},    32'(locked),      32'(m_state == 2));
    chk({tag, ".lost"},      32'(lost),        32'(m_lost));
    chk({tag, ".err_pulse"}, 32'(err_pulse),   32'(m_pulse));
    chk({tag, ".err_count"}, 32'(err_count),   32'(m_errc));
    chk({tag, ".last"},      32'(last_sample), 32'(m_last));
  endtask

  task automatic step(input logic v, input int s, input logic m, input logic c, input string tag);
    @(negedge clk);
    mon_if.sample_valid = v;
    mon_if.sample       = W'(s);
    mon_if.mode         = m;
    clear               = c;
    @(posedge clk);
    #1;
    model_update(v, s, m, c);
    check_model(tag);
  endtask

  task automatic samp(input int s, input logic m, input string tag);
    step(1'b1, s, m, 1'b0, tag);
  endtask

  task automatic do_clear();
    step(1'b0, 0, 1'b0, 1'b1, "clear");
  endtask

  initial begin
    bit v, m, c, good;
    int s;
    int pulses;

    rst = 1'b0;
    clear = 1'b0;
    mon_if.sample_valid = 1'b0;
    mon_if.sample = '0;
    mon_if.mode = 1'b0;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Lock up with wrap
    do_clear();
    samp(5, 1'b1, "up5"); chk("up5.state", 32'(state), 1);
    samp(6, 1'b1, "up6"); chk("up6.state", 32'(state), 1);
    samp(7, 1'b1, "up7"); chk("up7.state", 32'(state), 2); chk("up7.locked", 32'(locked), 1);
    samp(0, 1'b1, "up0"); chk("up0.state", 32'(state), 2);
    samp(1, 1'b1, "up1"); chk("up1.state", 32'(state), 2);
    chk("up.errc", 32'(err_count), 0);
    chk("up.last", 32'(last_sample), 1);

    // Lock down with wrap
    do_clear();
    samp(1, 1'b0, "dn1");
    samp(0, 1'b0, "dn0"); chk("dn0.err_pulse", 32'(err_pulse), 0);
    samp(7, 1'b0, "dn7"); chk("dn7.locked", 32'(locked), 1); chk("dn7.err_pulse", 32'(err_pulse), 0);
    samp(6, 1'b0, "dn6"); chk("dn6.err_pulse", 32'(err_pulse), 0);
    chk("dn.last", 32'(last_sample), 6);

    // Loss of lock then relock
    do_clear();
    samp(5, 1'b1, "ll5"); samp(6, 1'b1, "ll6"); samp(7, 1'b1, "ll7");
    samp(2, 1'b1, "llb1"); chk("llb1.pulse", 32'(err_pulse), 1);
    samp(2, 1'b1, "llb2"); chk("llb2.pulse", 32'(err_pulse), 1);
    samp(2, 1'b1, "llb3"); chk("llb3.pulse", 32'(err_pulse), 1);
    chk("ll.errc", 32'(err_count), 3);
    chk("ll.state", 32'(state), 3);
    chk("ll.lost", 32'(lost), 1);
    chk("ll.locked", 32'(locked), 0);
    samp(3, 1'b1, "rl3"); chk("rl3.pulse", 32'(err_pulse), 0);
    samp(4, 1'b1, "rl4");
    samp(5, 1'b1, "rl5");
    chk("rl.state", 32'(state), 2);
    chk("rl.lost", 32'(lost), 1);

    // Recovery before limit
    do_clear();
    samp(5, 1'b1, "rc5"); samp(6, 1'b1, "rc6"); samp(7, 1'b1, "rc7");
    samp(2, 1'b1, "rce1"); chk("rce1.state", 32'(state), 2);
    samp(3, 1'b1, "rcg1"); chk("rcg1.state", 32'(state), 2);
    samp(5, 1'b1, "rce2"); chk("rce2.state", 32'(state), 2);
    samp(6, 1'b1, "rcg2"); chk("rcg2.state", 32'(state), 2);
    chk("rc.errc", 32'(err_count), 2);

    // Clear and direction change
    do_clear();
    samp(1, 1'b1, "cd1"); samp(2, 1'b1, "cd2"); samp(3, 1'b1, "cd3");
    chk("cd3.locked", 32'(locked), 1);
    samp(2, 1'b0, "cdrev"); chk("cdrev.pulse", 32'(err_pulse), 0); chk("cdrev.last", 32'(last_sample), 2);
    step(1'b1, 4, 1'b1, 1'b1, "cdclr");
    chk("cdclr.state", 32'(state), 0);
    chk("cdclr.last", 32'(last_sample), 0);
    chk("cdclr.errc", 32'(err_count), 0);

    // Async reset mid-run
    do_clear();
    samp(5, 1'b1, "ar5"); samp(6, 1'b1, "ar6"); samp(7, 1'b1, "ar7");
    samp(2, 1'b1, "are1"); samp(3, 1'b1, "arg"); samp(5, 1'b1, "are2");
    chk("ar.errc", 32'(err_count), 2);
    chk("ar.state", 32'(state), 2);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_model("arst");
    @(negedge clk);
    rst = 1'b1;
    samp(4, 1'b1, "ar4");
    chk("ar4.state", 32'(state), 1);

    // Saturation of err_count: alternate bad/good so lock is held
    do_clear();
    samp(0, 1'b1, "sat0"); samp(1, 1'b1, "sat1"); samp(2, 1'b1, "sat2");
    pulses = 0;
    for (int i = 0; i < 260; i++) begin
      s = (m_last + 4) % 8;
      samp(s, 1'b1, "satb");
      pulses += int'(err_pulse);
      samp(next_of(m_last, 1'b1), 1'b1, "satg");
    end
    chk("sat.errc", 32'(err_count), 255);
    chk("sat.pulses", 32'(pulses), 260);
    chk("sat.state", 32'(state), 2);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      v    = ($urandom_range(0, 99) < 85);
      m    = 1'($urandom_range(0, 1));
      good = ($urandom_range(0, 99) < 75);
      c    = ($urandom_range(0, 99) < 2);
      s    = good ? next_of(m_last, m) : int'($urandom_range(0, 7));
      step(v, s, m, c, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
# count_monitor

Sequence monitor for the 3-bit up/down count stream produced by the team's counter. It samples the count on a valid strobe and checks that each new value is the previous value plus or minus one, modulo 2^WIDTH, in the direction given by `mode`. Once it has acquired lock on the stream, it reports step errors, keeps a saturating error count and declares loss of lock. It sits on the consumer side of the counter output in the practice testbench fabric, giving cocotb benches a hardware checker.

## Interface
- WIDTH, 3, width of the monitored count
- LOCK_LEN, 2, consecutive good steps needed to enter LOCKED (1..15)
- ERR_LIMIT, 3, consecutive bad steps in LOCKED that force LOST (1..15)

- clk  in  1  single clock; all logic on posedge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- clear  in  1  synchronous clear; returns to IDLE and zeroes the counters and flags
- sample_valid  in  1  `sample` and `mode` are valid this cycle
- sample  in  WIDTH  observed count value
- mode  in  1  expected direction of this step: 1 = up (+1), 0 = down (-1)
- state  out  2  IDLE=0, ACQUIRE=1, LOCKED=2, LOST=3
- locked  out  1  high when state == LOCKED
- lost  out  1  sticky loss-of-lock flag
- err_pulse  out  1  one-cycle pulse per step error while LOCKED
- err_count  out  8  total step errors while LOCKED, saturates at 255
- last_sample  out  WIDTH  most recent accepted sample

## Operation
- Expected value = `last_sample + 1` if `mode` is 1, else `last_sample - 1`, truncated to WIDTH bits. This wraps: 7→0 up and 0→7 down.
- `mode` is evaluated per sample. A direction change is legal if the new step matches the new mode.
- Every accepted sample, good or bad, updates `last_sample` in every state.
- Internal good_cnt and bad_cnt are 4 bits each.
- IDLE: on valid, store the sample, set good_cnt=0 and go to ACQUIRE. No check is made.
- ACQUIRE:
  - Match: good_cnt++. When good_cnt reaches LOCK_LEN, go to LOCKED and set bad_cnt=0.
  - Mismatch: good_cnt=0 and stay in ACQUIRE. No err_pulse and no err_count change.
- LOCKED:
  - Match: bad_cnt=0.
  - Mismatch: err_pulse=1, err_count++ (saturating), bad_cnt++. When bad_cnt reaches ERR_LIMIT, go to LOST and set `lost`=1.
- LOST: on valid, store the sample, set good_cnt=0 and go to ACQUIRE. `lost` stays 1 until clear or reset. Re-lock is allowed and does not clear `lost`.
- clear has priority over sample_valid in the same cycle: the sample is discarded, and clear moves to IDLE with err_count=0, lost=0, good_cnt=bad_cnt=0, last_sample=0.
- When sample_valid is 0, all state holds and err_pulse is 0.

## Timing
- Reset (rst=0, asynchronous, no clock needed) forces:
  - state=IDLE, locked=0, lost=0, err_pulse=0, err_count=0, last_sample=0
  - good_cnt=bad_cnt=0
- Release is taken on the first posedge with rst=1.
- All outputs are registered. A sample accepted at edge N is reflected in state, locked, lost, err_pulse, err_count and last_sample after edge N.
- err_pulse is high for exactly one cycle per erroneous sample. Back-to-back errors give a continuous high, one pulse per cycle.
- Lock latency is LOCK_LEN+1 valid samples: with LOCK_LEN=2, locked rises after the third valid sample's edge.
- Reset asserted mid-operation (any state) clears everything immediately. Pending counts are lost.

## Test plan
- Lock up with wrap: mode=1, samples 5,6,7,0,1 on consecutive cycles.
  - state after each edge: 1,1,2,2,2.
  - locked=1 after the third sample, err_count=0, last_sample=1.
- Lock down with wrap: mode=0, samples 1,0,7,6.
  - Locked after sample 7.
  - No err_pulse, last_sample=6.
- Loss of lock: lock with 5,6,7 (mode=1), then 2,2,2.
  - err_pulse high for three cycles, err_count=3.
  - state=LOST, lost=1, locked=0.
  - A further 3,4,5 relocks (state=2) with lost still 1.
- Recovery before limit: lock with 5,6,7, then 2 (err), 3 (good), 5 (err), 6 (good).
  - err_count=2 and state stays LOCKED throughout, because bad_cnt resets on each good step.
- Clear and direction change:
  - Locked at 3 (mode=1); send 2 with mode=0. This is good: no error, last_sample=2.
  - Then assert clear and sample_valid together with sample=4. Result: state=IDLE, last_sample=0, err_count=0, and sample 4 is discarded.
- Async reset mid-run: while LOCKED with err_count=2, drive rst=0 between clock edges.
  - All outputs go to 0 / IDLE before the next posedge.
  - After release, the next sample 4 gives state=ACQUIRE.
